// File: rtl/hu_stall_ctrl.sv
// Hazard-unit stall/flush controller: load-use bubbles, branch redirect flushes,
// memory freeze, plus saturating statistics counters.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal issue; evaluate freeze, redirect, then load-use hazard
// LU_WAIT  | extra load-use bubble cycles pending, counted down in lu_cnt
// MEM_WAIT | pipeline frozen on an outstanding data-memory access
module hu_stall_ctrl #(
   parameter int LOAD_USE_CYCLES = 1,
   parameter int CNT_W           = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             MemRead_E,
   input  logic [4:0]       Rd_E,
   input  logic [4:0]       Rs1_D,
   input  logic [4:0]       Rs2_D,
   input  logic             reg_ren_D,
   input  logic             rs2_used_D,
   input  logic             redirect_E,
   input  logic             mem_req_M,
   input  logic             mem_ready_M,
   output logic             stall_F,
   output logic             stall_D,
   output logic             stall_E,
   output logic             stall_M,
   output logic             flush_D,
   output logic             flush_E,
   output logic             bubble_W,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, LU_WAIT, MEM_WAIT} state_t;

   localparam logic [2:0] LU_INIT = 3'(LOAD_USE_CYCLES - 1);

   state_t     state, state_nxt;
   logic [2:0] lu_cnt, lu_cnt_nxt;
   logic       lu_hit, mem_busy;

   assign lu_hit   = MemRead_E && (Rd_E != 5'd0) &&
                     ((reg_ren_D && (Rs1_D == Rd_E)) || (rs2_used_D && (Rs2_D == Rd_E)));
   assign mem_busy = mem_req_M && !mem_ready_M;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RUN;
         lu_cnt <= 3'd0;
      end else begin
         state  <= state_nxt;
         lu_cnt <= lu_cnt_nxt;
      end
   end

   // MEM_WAIT releases with zero latency, so it shares RUN's decision tree.
   always_comb begin
      state_nxt  = state;
      lu_cnt_nxt = lu_cnt;
      case (state)
         LU_WAIT: begin
            if (!mem_busy) begin
               lu_cnt_nxt = lu_cnt - 3'd1;
               if (lu_cnt == 3'd1) state_nxt = RUN;
            end
         end
         default: begin
            if (mem_busy) begin
               state_nxt = MEM_WAIT;
            end else if (redirect_E) begin
               state_nxt = RUN;
            end else if (lu_hit && (LOAD_USE_CYCLES > 1)) begin
               state_nxt  = LU_WAIT;
               lu_cnt_nxt = LU_INIT;
            end else begin
               state_nxt = RUN;
            end
         end
      endcase
   end

   always_comb begin
      stall_F  = 1'b0;
      stall_D  = 1'b0;
      stall_E  = 1'b0;
      stall_M  = 1'b0;
      flush_D  = 1'b0;
      flush_E  = 1'b0;
      bubble_W = 1'b0;
      if (!rst) begin
         if (mem_busy) begin
            stall_F  = 1'b1;
            stall_D  = 1'b1;
            stall_E  = 1'b1;
            stall_M  = 1'b1;
            bubble_W = 1'b1;
         end else if (state == LU_WAIT) begin
            // E already holds a bubble here, so a redirect cannot be live.
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
         end else if (redirect_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
         end else if (lu_hit) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_F && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_D && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/hu_stall_ctrl.md
HU_STALL_CTRL -- requirements
Module: hu_stall_ctrl

Interface
REQ-001 SHALL have parameter LOAD_USE_CYCLES, default 1, giving the bubble cycles inserted per load-use hazard (legal 1..7).
REQ-002 SHALL have parameter CNT_W, default 32, giving the statistics counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port MemRead_E, input, 1, meaning a load is in E.
REQ-006 SHALL have port Rd_E, input, 5, the E-stage destination register.
REQ-007 SHALL have ports Rs1_D and Rs2_D, input, 5 each, the D-stage source registers.
REQ-008 SHALL have port reg_ren_D, input, 1, meaning the D instruction reads Rs1.
REQ-009 SHALL have port rs2_used_D, input, 1, meaning the D instruction reads Rs2.
REQ-010 SHALL have port redirect_E, input, 1, meaning a taken branch or jump resolved in E.
REQ-011 SHALL have port mem_req_M, input, 1, a data-memory access in M.
REQ-012 SHALL have port mem_ready_M, input, 1, memory response valid this cycle.
REQ-013 SHALL have ports stall_F, stall_D, stall_E and stall_M, output, 1 each, meaning hold that stage's pipeline register.
REQ-014 SHALL have ports flush_D and flush_E, output, 1 each, meaning load a bubble into the D and E registers.
REQ-015 SHALL have port bubble_W, output, 1, meaning insert a bubble into W.
REQ-016 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each, the statistics counters.

Function
REQ-017 SHALL define lu_hit = MemRead_E & (Rd_E!=0) & ((reg_ren_D & Rs1_D==Rd_E) | (rs2_used_D & Rs2_D==Rd_E)).
REQ-018 SHALL define mem_busy = mem_req_M & !mem_ready_M.
REQ-019 SHALL implement a three-state FSM with states RUN, LU_WAIT and MEM_WAIT; outputs are combinational from state and inputs.
REQ-020 RUN, priority 1: if mem_busy, SHALL assert stall_F, stall_D, stall_E, stall_M and bubble_W, with no flushes, and go to MEM_WAIT.
REQ-021 RUN, priority 2: if redirect_E, SHALL assert flush_D and flush_E, with no stalls, and stay in RUN; redirect overrides lu_hit.
REQ-022 RUN, priority 3: if lu_hit, SHALL assert stall_F, stall_D and flush_E.
REQ-023 RUN, priority 3, next state: go to LU_WAIT with lu_cnt=LOAD_USE_CYCLES-1 when LOAD_USE_CYCLES>1, else stay in RUN.
REQ-024 RUN, otherwise: SHALL drive all outputs 0.
REQ-025 LU_WAIT, if mem_busy: SHALL assert all four stalls and bubble_W, hold lu_cnt, and stay in LU_WAIT.
REQ-026 LU_WAIT, otherwise: SHALL assert stall_F, stall_D and flush_E, decrement lu_cnt, and go to RUN when lu_cnt==1.
REQ-027 LU_WAIT SHALL ignore redirect_E, because E holds a bubble.
REQ-028 MEM_WAIT, while mem_busy: SHALL assert all four stalls and bubble_W.
REQ-029 MEM_WAIT, when !mem_busy: SHALL produce the RUN outputs and next state for the current inputs in that same cycle (zero-latency release).
REQ-030 lu_cnt SHALL be 3 bits wide.
REQ-031 stall_cnt SHALL increment by 1 in each cycle that stall_F=1, saturating at all-ones.
REQ-032 flush_cnt SHALL increment by 1 in each cycle that flush_D=1, saturating at all-ones.
REQ-033 A load-use hazard SHALL produce exactly LOAD_USE_CYCLES cycles of stall_F excluding memory-freeze cycles; a hazard whose Rd_E is x0 SHALL produce none.
REQ-034 mem_ready_M arriving in the same cycle as mem_req_M SHALL cause no stall.

Reset
REQ-035 While rst=1 at a clock edge, the FSM SHALL go to RUN and lu_cnt, stall_cnt and flush_cnt SHALL go to 0.
REQ-036 While rst=1, all stall, flush and bubble outputs SHALL be driven 0.
REQ-037 Reset asserted mid-LU_WAIT or mid-MEM_WAIT SHALL abandon the sequence with no residual stall after rst deasserts.

Verification
REQ-038 Load-use bubble: LOAD_USE_CYCLES=1, MemRead_E=1, Rd_E=5, Rs1_D=5, reg_ren_D=1 -> stall_F=stall_D=flush_E=1 for 1 cycle, then 0; stall_cnt=1.
REQ-039 Extended load-use: LOAD_USE_CYCLES=3, same hazard -> stall_F=1 for 3 consecutive cycles, then RUN; stall_cnt=3.
REQ-040 x0 and Rs2 hazards: Rd_E=0, Rs1_D=0 -> no stall; Rd_E=7, Rs2_D=7, rs2_used_D=0 -> no stall; with rs2_used_D=1 -> stall.
REQ-041 Redirect priority: redirect_E=1 together with lu_hit=1 -> flush_D=flush_E=1, stall_F=0; flush_cnt=1.
REQ-042 Memory freeze: mem_req_M=1, mem_ready_M=0 for 4 cycles, then 1 -> all stalls and bubble_W=1 for 4 cycles, 0 on the ready cycle; stall_cnt=4.
REQ-043 Memory freeze mid-bubble and reset: LOAD_USE_CYCLES=3 with mem_busy on the 2nd bubble cycle for 2 cycles -> lu_cnt held, total stall_F=5.
REQ-044 Reset mid-freeze: rst=1 asserted during MEM_WAIT -> all outputs 0 and counters 0 on the next cycle.
